// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned OS16 = 16;
  localparam int unsigned OS8  = 8;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  function automatic logic [4:0] os_ticks(input logic os16);
    return os16 ? 5'(OS16) : 5'(OS8);
  endfunction

endpackage

// File: rtl/rx_frame_ctrl.sv
// UART receive framing: start validation, mid-bit sampling, LSB-first shift,
// parity/stop checking, all advanced by the oversample tick BaudOut.
module rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              BaudOut,
  input  logic              OverSel,
  input  logic [1:0]        ParityType,
  input  logic              RxIn,
  output logic [DATA_W-1:0] RxData,
  output logic              Done,
  output logic              ParityErr,
  output logic              StopErr,
  output logic              Busy
);

  localparam int unsigned BCW = $clog2(DATA_W + 1);

  rx_state_e         state_q, state_d;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              os16_q, os16_d;
  logic [1:0]        par_q, par_d;
  logic              perr_q, perr_d;
  logic              done_q, done_d;
  logic              parity_err_q, parity_err_d;
  logic              stop_err_q, stop_err_d;

  logic [4:0]        os;
  logic [4:0]        os_half;
  logic [4:0]        tick_next;

  assign os        = os_ticks(os16_q);
  assign os_half   = os >> 1;
  // 5-bit so the 16x wrap point (15 + 1) is comparable without overflow
  assign tick_next = {1'b0, tick_cnt_q} + 5'd1;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    os16_d       = os16_q;
    par_d        = par_q;
    perr_d       = perr_q;
    done_d       = 1'b0;
    parity_err_d = parity_err_q;
    stop_err_d   = stop_err_q;

    if (BaudOut) begin
      case (state_q)
        IDLE: begin
          if (!RxIn) begin
            state_d    = START;
            tick_cnt_d = 4'd1;
            os16_d     = OverSel;
            par_d      = ParityType;
            perr_d     = 1'b0;
          end
        end
        START: begin
          if (tick_next == os_half) begin
            tick_cnt_d = '0;
            if (RxIn) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_next[3:0];
          end
        end
        DATA: begin
          if (tick_next == os) begin
            tick_cnt_d = '0;
            shift_d    = {RxIn, shift_q[DATA_W-1:1]};
            bit_cnt_d  = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(DATA_W - 1)) begin
              state_d = parity_enabled(par_q) ? PARITY : STOP;
            end
          end else begin
            tick_cnt_d = tick_next[3:0];
          end
        end
        PARITY: begin
          if (tick_next == os) begin
            tick_cnt_d = '0;
            perr_d     = ((^shift_q) ^ RxIn) != (par_q == PAR_ODD);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_next[3:0];
          end
        end
        STOP: begin
          // back to IDLE at mid-stop so a following start edge is caught at once
          if (tick_next == os) begin
            tick_cnt_d   = '0;
            state_d      = IDLE;
            done_d       = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            stop_err_d   = ~RxIn;
          end else begin
            tick_cnt_d = tick_next[3:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      os16_q       <= 1'b0;
      par_q        <= PAR_NONE;
      perr_q       <= 1'b0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      os16_q       <= os16_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
      stop_err_q   <= stop_err_d;
    end
  end

  assign RxData    = rx_data_q;
  assign Done      = done_q;
  assign ParityErr = parity_err_q;
  assign StopErr   = stop_err_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: a tick-schedule line model compared every cycle,
// plus literal per-frame expectations.
module tb_rx_frame_ctrl;

  localparam int unsigned DATA_W = 8;

  logic              Clock = 1'b0;
  logic              ResetN = 1'b0;
  logic              BaudOut = 1'b0;
  logic              OverSel = 1'b1;
  logic [1:0]        ParityType = 2'b00;
  logic              RxIn = 1'b1;
  logic [DATA_W-1:0] RxData;
  logic              Done;
  logic              ParityErr;
  logic              StopErr;
  logic              Busy;

  rx_frame_ctrl #(.DATA_W(DATA_W)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .BaudOut    (BaudOut),
    .OverSel    (OverSel),
    .ParityType (ParityType),
    .RxIn       (RxIn),
    .RxData     (RxData),
    .Done       (Done),
    .ParityErr  (ParityErr),
    .StopErr    (StopErr),
    .Busy       (Busy)
  );

  always #10 Clock = ~Clock;

  int n_pass  = 0;
  int n_total = 0;
  int tb_ticks = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Line model: phase -1 idle, 0 start, 1 data, 2 parity, 3 stop.
  int   m_phase = -1;
  int   m_wait  = 0;
  int   m_os    = 16;
  int   m_bits  = 0;
  int   m_word  = 0;
  int   m_data  = 0;
  logic [1:0] m_par = 2'b00;
  logic m_perr_pend = 1'b0;
  logic m_done = 1'b0;
  logic m_perr = 1'b0;
  logic m_serr = 1'b0;
  logic m_busy = 1'b0;

  initial forever begin
    @(posedge Clock or negedge ResetN);
    if (!ResetN) begin
      m_phase = -1; m_done = 0; m_data = 0; m_perr = 0; m_serr = 0; m_busy = 0;
    end else begin
      m_done = 0;
      if (BaudOut) begin
        tb_ticks++;
        if (m_phase < 0) begin
          if (!RxIn) begin
            m_os = OverSel ? 16 : 8;
            m_par = ParityType;
            m_wait = m_os / 2 - 1;
            m_phase = 0;
            m_perr_pend = 0;
            m_word = 0;
            m_bits = 0;
          end
        end else begin
          m_wait = m_wait - 1;
          if (m_wait == 0) begin
            m_wait = m_os;
            case (m_phase)
              0: m_phase = RxIn ? -1 : 1;
              1: begin
                if (RxIn) m_word = m_word | (1 << m_bits);
                m_bits++;
                if (m_bits == DATA_W)
                  m_phase = (m_par == 2'b01 || m_par == 2'b10) ? 2 : 3;
              end
              2: begin
                m_perr_pend = (($countones(m_word) + int'(RxIn)) % 2) != ((m_par == 2'b01) ? 1 : 0);
                m_phase = 3;
              end
              default: begin
                m_done = 1;
                m_data = m_word;
                m_perr = m_perr_pend;
                m_serr = !RxIn;
                m_phase = -1;
              end
            endcase
          end
        end
      end
      m_busy = (m_phase >= 0);
    end
  end

  int   dut_done_cnt = 0;
  int   cap_data = 0;
  int   cap_tick = 0;
  logic cap_perr = 0;
  logic cap_serr = 0;

  initial forever begin
    @(negedge Clock);
    if (ResetN) begin
      chk("done", Done, m_done);
      chk("rx_data", RxData, m_data);
      chk("parity_err", ParityErr, m_perr);
      chk("stop_err", StopErr, m_serr);
      chk("busy", Busy, m_busy);
      if (Done) begin
        dut_done_cnt++;
        cap_data = RxData;
        cap_perr = ParityErr;
        cap_serr = StopErr;
        cap_tick = tb_ticks;
      end
    end
  end

  task automatic tick();
    @(negedge Clock); BaudOut = 1'b1;
    @(negedge Clock); BaudOut = 1'b0;
    @(negedge Clock);
  endtask

  task automatic send_bits(input logic v, input int n);
    RxIn = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int os, input logic has_par,
                            input logic pbit, input logic stop, input int toggle_bit);
    send_bits(1'b0, os);
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i == toggle_bit) OverSel = ~OverSel;
      send_bits(d[i], os);
    end
    if (has_par) send_bits(pbit, os);
    send_bits(stop, os);
    RxIn = 1'b1;
  endtask

  task automatic expect_frame(input string nm, input int exp_cnt, input int data,
                              input int perr, input int serr);
    #1;
    chk({nm, "_done_cnt"}, dut_done_cnt, exp_cnt);
    chk({nm, "_data"}, cap_data, data);
    chk({nm, "_perr"}, cap_perr, perr);
    chk({nm, "_serr"}, cap_serr, serr);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_done"}, Done, 0);
    chk({nm, "_rx_data"}, RxData, 0);
    chk({nm, "_perr"}, ParityErr, 0);
    chk({nm, "_serr"}, StopErr, 0);
    chk({nm, "_busy"}, Busy, 0);
  endtask

  initial begin
    int c;
    int s;

    repeat (3) @(negedge Clock);
    #1 check_all_zero("reset");
    @(negedge Clock); ResetN = 1'b1;
    send_bits(1'b1, 4);

    // 16x even parity, 0xA5 (four ones -> parity 0); stop sample 7 + 16*10 ticks after start
    OverSel = 1'b1; ParityType = 2'b10;
    c = dut_done_cnt; s = tb_ticks + 1;
    send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b1, -1);
    expect_frame("a5_even16", c + 1, 'hA5, 0, 0);
    chk("a5_latency", cap_tick - s, 167);

    // reset in the middle of DATA
    send_bits(1'b1, 4);
    send_bits(1'b0, 16);
    send_bits(1'b1, 20);
    #1 chk("pre_reset_busy", Busy, 1);
    #4 ResetN = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge Clock); ResetN = 1'b1;
    send_bits(1'b1, 4);
    c = dut_done_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
    expect_frame("3c_after_reset", c + 1, 'h3C, 0, 0);

    // 8x no parity, 0x5A; stop sample 3 + 8*9 ticks after start
    send_bits(1'b1, 4);
    OverSel = 1'b0; ParityType = 2'b00;
    c = dut_done_cnt; s = tb_ticks + 1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
    expect_frame("5a_nopar8", c + 1, 'h5A, 0, 0);
    chk("5a_latency", cap_tick - s, 75);

    // odd parity errors
    send_bits(1'b1, 4);
    OverSel = 1'b1; ParityType = 2'b01;
    c = dut_done_cnt;
    send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1, -1);
    expect_frame("01_bad_odd", c + 1, 'h01, 1, 0);
    send_bits(1'b1, 4);
    c = dut_done_cnt;
    send_frame(8'hFF, 16, 1'b1, 1'b1, 1'b0, -1);
    expect_frame("ff_stop_err", c + 1, 'hFF, 0, 1);
    // the low stop tail restarts reception; let that frame run out
    send_bits(1'b1, 200);

    // false start: 2 low ticks, validation at tick 8
    OverSel = 1'b1; ParityType = 2'b00;
    c = dut_done_cnt;
    send_bits(1'b0, 2);
    send_bits(1'b1, 5);
    #1 chk("false_start_busy_t7", Busy, 1);
    send_bits(1'b1, 1);
    #1 chk("false_start_busy_t8", Busy, 0);
    send_bits(1'b1, 4);
    #1 chk("false_start_no_done", dut_done_cnt, c);

    // back-to-back, OverSel toggled during the first frame
    OverSel = 1'b1; ParityType = 2'b10;
    c = dut_done_cnt;
    send_frame(8'h11, 16, 1'b1, 1'b0, 1'b1, 3);
    expect_frame("11_b2b", c + 1, 'h11, 0, 0);
    send_frame(8'h22, 8, 1'b1, 1'b0, 1'b1, -1);
    expect_frame("22_b2b", c + 2, 'h22, 0, 0);
    send_bits(1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- UART receive controller that sequences the oversampling baud generator (Sampling) output into framed data reception.
- Consumes the one-Clock oversample tick BaudOut together with the serial line.
- Detects and validates the start bit, samples each bit at mid-point, shifts data LSB first, and checks parity and stop.
- Sits in the UART-Rx top, between Sampling and the receive data register/consumer.

Parameters:
- DATA_W, 8, number of data bits per frame (5..9).

Ports:
- Clock  input  1  system clock, 50 MHz.
- ResetN  input  1  asynchronous active-low reset.
- BaudOut  input  1  oversample tick from Sampling; one-Clock-wide pulse.
- OverSel  input  1  oversampling select: 1 = 16 ticks/bit, 0 = 8 ticks/bit; must match Sampling.
- ParityType  input  2  parity select: 01 = odd, 10 = even, 00/11 = no parity.
- RxIn  input  1  serial line, already synchronous to Clock (synchronizer upstream); idle high.
- RxData  output  DATA_W  received word; valid when Done is high, held until the next Done.
- Done  output  1  one-Clock pulse at frame completion.
- ParityErr  output  1  parity mismatch of the last frame; updated with Done.
- StopErr  output  1  stop bit sampled low in the last frame; updated with Done.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE.
  - RxData = 0, Done = 0, ParityErr = 0, StopErr = 0, Busy = 0.
  - Counters and shift register cleared.
- Tick gating:
  - All counting and sampling advance only on Clock edges where BaudOut = 1.
  - Clocks without a tick hold the state.
- Configuration capture:
  - OS = 16 if OverSel = 1, else 8.
  - OS and ParityType are latched on IDLE→START.
  - Mid-frame changes are ignored until the next frame.
- Registers:
  - tick_cnt: 4 bits, counts ticks within a bit.
  - bit_cnt: counts data bits.
- IDLE:
  - On a tick with RxIn = 0: go to START, tick_cnt = 1.
- START:
  - On each tick, tick_cnt++.
  - When tick_cnt reaches OS/2 (8 or 4), sample RxIn.
  - If RxIn = 1: false start, return to IDLE with no flags and no Done.
  - If RxIn = 0: go to DATA with tick_cnt = 0 and bit_cnt = 0.
- DATA:
  - On each tick, tick_cnt++.
  - When tick_cnt wraps at OS (mid-bit), shift RxIn into the MSB of the shift register (LSB-first frame) and increment bit_cnt.
  - After DATA_W bits: go to PARITY if ParityType is 01/10, else go to STOP.
- PARITY:
  - Sample after OS ticks.
  - perr = (XOR of data ^ sampled bit) != (ParityType == 01).
  - Even parity: XOR of data and parity bit = 0. Odd parity: = 1.
- STOP:
  - Sample after OS ticks.
  - In the same Clock: RxData <= shift register, Done = 1, ParityErr <= perr (0 if no parity), StopErr <= ~RxIn.
  - Return to IDLE.
  - A frame with a stop error is still delivered.
- Done: high for exactly one Clock, registered output; zero-latency relative to the stop-sample tick edge.
- Back-to-back frames:
  - Returning to IDLE at mid-stop allows the next start edge to be detected on the first low tick.
  - No idle gap is required.
- Stuck low: if the line is held low after a stop error, IDLE immediately re-enters START. This is intended (break behaves as repeated errored frames).
- Busy is combinationally derived from state != IDLE.

Decomposition:
- Shared package uart_rx_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Parity codes (PAR_NONE = 00, PAR_ODD = 01, PAR_EVEN = 10).
  - Oversample constants OS16 = 16, OS8 = 8.
- Single module; no sub-module is warranted.
- Sampling is instantiated beside this block in the UART-Rx top, not inside it.

Test Plan:
- Reset mid-frame: send a start bit, assert ResetN = 0 during DATA → all outputs 0 and state IDLE immediately; next clean frame 0x3C is received correctly.
- Nominal frame, 16x, even parity: OverSel = 1, ParityType = 10, frame 0xA5 with parity 0 and stop 1 → RxData = 0xA5, Done single pulse, ParityErr = 0, StopErr = 0.
- Nominal frame, 8x, no parity: OverSel = 0, ParityType = 00, frame 0x5A → RxData = 0x5A, Done pulse about 9.5 bit times after the start edge, no errors.
- Errored frames, odd parity: ParityType = 01, frame 0x01 with wrong parity bit 1 → ParityErr = 1. Then frame 0xFF with stop = 0 → StopErr = 1, RxData = 0xFF.
- False start: RxIn low for 2 ticks then high, OverSel = 1 → no Done, Busy returns to 0 at tick 8.
- Back-to-back and config change: frames 0x11 and 0x22 with no idle gap → two Done pulses with correct data. Toggle OverSel during the first frame → the first frame is still decoded at the latched OS.
